// File: rtl/bin_to_bcd_seg_pkg.sv
// Shared encodings and constants for the binary-to-BCD seven-segment path.
package bin_to_bcd_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int CONV_STEPS = 8;

    // Active-high segment codes, bit[6:0] = g..a, dp and bit8 unused.
    localparam logic [8:0] SEG_0     = 9'h03f;
    localparam logic [8:0] SEG_1     = 9'h006;
    localparam logic [8:0] SEG_2     = 9'h05b;
    localparam logic [8:0] SEG_3     = 9'h04f;
    localparam logic [8:0] SEG_4     = 9'h066;
    localparam logic [8:0] SEG_5     = 9'h06d;
    localparam logic [8:0] SEG_6     = 9'h07d;
    localparam logic [8:0] SEG_7     = 9'h007;
    localparam logic [8:0] SEG_8     = 9'h07f;
    localparam logic [8:0] SEG_9     = 9'h06f;
    localparam logic [8:0] SEG_BLANK = 9'h000;

    // Double-dabble correction; a BCD nibble of 5..9 becomes 8..12, never carries.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seg_seg7_encode.sv
// Combinational BCD digit to seven-segment lookup; non-decimal codes go blank.
module seg7_encode
    import bin_to_bcd_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [8:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin_to_bcd_seg.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3) with
// seven-segment outputs and optional leading-zero blanking.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for start; work register loaded on acceptance
// ST_SHIFT | one add-3/shift step per cycle, CONV_STEPS steps
// ST_LATCH | publish bcd/ovf, pulse done, return to idle
module bin_to_bcd_seg
    import bin_to_bcd_seg_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [11:0] bcd,
    output logic       ovf,
    output logic [8:0] seg_led_h,
    output logic [8:0] seg_led_1,
    output logic [8:0] seg_led_2
);

    localparam logic [2:0] LAST_STEP = 3'(CONV_STEPS - 1);

    state_t      state;
    logic [19:0] work;
    logic [2:0]  step;
    logic [19:0] adjusted;
    logic [19:0] shifted;

    always_comb begin
        adjusted = {add3(work[19:16]), add3(work[15:12]), add3(work[11:8]), work[7:0]};
        shifted  = {adjusted[18:0], 1'b0};
    end

    // busy stays high through the done cycle so a start during LATCH is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= 12'h000;
            ovf   <= 1'b0;
            work  <= 20'h00000;
            step  <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= start;
                    if (start) begin
                        work  <= {12'h000, value};
                        step  <= 3'd0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    busy <= 1'b1;
                    work <= shifted;
                    step <= step + 3'd1;
                    if (step == LAST_STEP) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    busy  <= 1'b1;
                    bcd   <= work[19:8];
                    ovf   <= (work[19:16] != 4'd0);
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic [8:0] seg_h_raw;
    logic [8:0] seg_t_raw;

    seg7_encode u_seg_h (.digit(bcd[11:8]), .seg(seg_h_raw));
    seg7_encode u_seg_t (.digit(bcd[7:4]),  .seg(seg_t_raw));
    seg7_encode u_seg_o (.digit(bcd[3:0]),  .seg(seg_led_2));

    always_comb begin
        seg_led_h = seg_h_raw;
        seg_led_1 = seg_t_raw;
        if (BLANK_LZ && bcd[11:8] == 4'd0) begin
            seg_led_h = SEG_BLANK;
            if (bcd[7:4] == 4'd0) begin
                seg_led_1 = SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seg.sv
// Directed bench for bin_to_bcd_seg: two instances (blanking on and off) share stimulus.
module tb_bin_to_bcd_seg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  value = 8'd0;
    logic        start = 1'b0;

    logic        busy, done, ovf;
    logic [11:0] bcd;
    logic [8:0]  seg_led_h, seg_led_1, seg_led_2;

    logic        busy_nb, done_nb, ovf_nb;
    logic [11:0] bcd_nb;
    logic [8:0]  seg_h_nb, seg_1_nb, seg_2_nb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seg #(.BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .start(start),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf),
        .seg_led_h(seg_led_h), .seg_led_1(seg_led_1), .seg_led_2(seg_led_2)
    );

    bin_to_bcd_seg #(.BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .start(start),
        .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .ovf(ovf_nb),
        .seg_led_h(seg_h_nb), .seg_led_1(seg_1_nb), .seg_led_2(seg_2_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns just after that edge (edge k).
    task automatic pulse_start(input logic [7:0] v);
        value = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits up to 20 edges for done; cyc = edges waited, or -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        tests++; if (bcd !== 12'h000) begin fails++; $display("FAIL reset_bcd got %h want 000", bcd); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (seg_led_2 !== 9'h03f) begin fails++; $display("FAIL reset_seg2 got %h want 03f", seg_led_2); end
        tests++; if (seg_led_1 !== 9'h000) begin fails++; $display("FAIL reset_seg1 got %h want 000", seg_led_1); end
        tests++; if (seg_led_h !== 9'h000) begin fails++; $display("FAIL reset_segh got %h want 000", seg_led_h); end
        tests++; if (seg_1_nb !== 9'h03f) begin fails++; $display("FAIL reset_seg1_nb got %h want 03f", seg_1_nb); end
        tests++; if (seg_h_nb !== 9'h03f) begin fails++; $display("FAIL reset_segh_nb got %h want 03f", seg_h_nb); end
    endtask

    task automatic test_timing_99();
        int done_cnt = 0;
        pulse_start(8'd99);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL t99_busy_k got %b want 1", busy); end
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (done) done_cnt++;
            tests++;
            if (done !== (j == 9)) begin
                fails++; $display("FAIL t99_done_edge%0d got %b want %b", j, done, (j == 9));
            end
            tests++;
            if (busy !== (j <= 9)) begin
                fails++; $display("FAIL t99_busy_edge%0d got %b want %b", j, busy, (j <= 9));
            end
            if (j == 9) begin
                tests++; if (bcd !== 12'h099) begin fails++; $display("FAIL t99_bcd got %h want 099", bcd); end
                tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL t99_ovf got %b want 0", ovf); end
                tests++; if (seg_led_1 !== 9'h06f) begin fails++; $display("FAIL t99_seg1 got %h want 06f", seg_led_1); end
                tests++; if (seg_led_2 !== 9'h06f) begin fails++; $display("FAIL t99_seg2 got %h want 06f", seg_led_2); end
                tests++; if (seg_led_h !== 9'h000) begin fails++; $display("FAIL t99_segh got %h want 000", seg_led_h); end
            end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL t99_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_values();
        int cyc;
        pulse_start(8'd255);
        wait_done(cyc);
        tests++; if (cyc != 9) begin fails++; $display("FAIL t255_latency got %0d want 9", cyc); end
        tests++; if (bcd !== 12'h255) begin fails++; $display("FAIL t255_bcd got %h want 255", bcd); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL t255_ovf got %b want 1", ovf); end
        tests++; if (seg_led_h !== 9'h05b) begin fails++; $display("FAIL t255_segh got %h want 05b", seg_led_h); end
        tests++; if (seg_led_1 !== 9'h06d) begin fails++; $display("FAIL t255_seg1 got %h want 06d", seg_led_1); end
        tests++; if (seg_led_2 !== 9'h06d) begin fails++; $display("FAIL t255_seg2 got %h want 06d", seg_led_2); end
        tick();

        pulse_start(8'd100);
        wait_done(cyc);
        tests++; if (cyc != 9) begin fails++; $display("FAIL t100_latency got %0d want 9", cyc); end
        tests++; if (bcd !== 12'h100) begin fails++; $display("FAIL t100_bcd got %h want 100", bcd); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL t100_ovf got %b want 1", ovf); end
        tests++; if (seg_led_h !== 9'h006) begin fails++; $display("FAIL t100_segh got %h want 006", seg_led_h); end
        tests++; if (seg_led_1 !== 9'h03f) begin fails++; $display("FAIL t100_seg1 got %h want 03f", seg_led_1); end
        tests++; if (seg_led_2 !== 9'h03f) begin fails++; $display("FAIL t100_seg2 got %h want 03f", seg_led_2); end
        tick();

        pulse_start(8'd7);
        wait_done(cyc);
        tests++; if (bcd !== 12'h007) begin fails++; $display("FAIL t7_bcd got %h want 007", bcd); end
        tests++; if (seg_led_h !== 9'h000) begin fails++; $display("FAIL t7_segh got %h want 000", seg_led_h); end
        tests++; if (seg_led_1 !== 9'h000) begin fails++; $display("FAIL t7_seg1 got %h want 000", seg_led_1); end
        tests++; if (seg_led_2 !== 9'h007) begin fails++; $display("FAIL t7_seg2 got %h want 007", seg_led_2); end
        tests++; if (seg_h_nb !== 9'h03f) begin fails++; $display("FAIL t7_segh_nb got %h want 03f", seg_h_nb); end
        tests++; if (seg_1_nb !== 9'h03f) begin fails++; $display("FAIL t7_seg1_nb got %h want 03f", seg_1_nb); end
        tests++; if (seg_2_nb !== 9'h007) begin fails++; $display("FAIL t7_seg2_nb got %h want 007", seg_2_nb); end
        tests++; if (ovf_nb !== 1'b0) begin fails++; $display("FAIL t7_ovf_nb got %b want 0", ovf_nb); end
        tick();
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        int done_at = -1;
        pulse_start(8'd42);
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (done) begin done_cnt++; done_at = j; end
            if (j == 3) begin value = 8'd13; start = 1'b1; end
            if (j == 4) start = 1'b0;
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL b2b_done_count got %0d want 1", done_cnt); end
        tests++; if (done_at != 9) begin fails++; $display("FAIL b2b_done_edge got %0d want 9", done_at); end
        tests++; if (bcd !== 12'h042) begin fails++; $display("FAIL b2b_bcd1 got %h want 042", bcd); end

        // Start sampled at edge k+10, the first edge that accepts a new request.
        done_cnt = 0;
        done_at  = -1;
        pulse_start(8'd13);
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (done) begin done_cnt++; done_at = j; end
            if (j == 9) begin
                tests++; if (bcd !== 12'h013) begin fails++; $display("FAIL b2b_bcd2 got %h want 013", bcd); end
                tests++; if (seg_led_1 !== 9'h006) begin fails++; $display("FAIL b2b_seg1 got %h want 006", seg_led_1); end
                tests++; if (seg_led_2 !== 9'h04f) begin fails++; $display("FAIL b2b_seg2 got %h want 04f", seg_led_2); end
            end
        end
        tests++; if (done_cnt != 1 || done_at != 9) begin
            fails++; $display("FAIL b2b_done2 got count %0d edge %0d want count 1 edge 9", done_cnt, done_at);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        int cyc;
        pulse_start(8'd88);
        repeat (4) tick();
        rst = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
        tests++; if (bcd !== 12'h000) begin fails++; $display("FAIL rmid_bcd got %h want 000", bcd); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rmid_ovf got %b want 0", ovf); end
        tests++; if (seg_led_2 !== 9'h03f || seg_led_1 !== 9'h000 || seg_led_h !== 9'h000) begin
            fails++; $display("FAIL rmid_segs got %h %h %h want 000 000 03f", seg_led_h, seg_led_1, seg_led_2);
        end
        for (int j = 0; j < 2; j++) begin tick(); if (done) done_cnt++; end
        rst = 1'b1;
        for (int j = 0; j < 10; j++) begin tick(); if (done || busy) done_cnt++; end
        tests++; if (done_cnt != 0) begin fails++; $display("FAIL rmid_no_done got %0d want 0", done_cnt); end

        pulse_start(8'd88);
        wait_done(cyc);
        tests++; if (cyc != 9) begin fails++; $display("FAIL rmid_latency got %0d want 9", cyc); end
        tests++; if (bcd !== 12'h088) begin fails++; $display("FAIL rmid_bcd2 got %h want 088", bcd); end
        tests++; if (seg_led_1 !== 9'h07f || seg_led_2 !== 9'h07f) begin
            fails++; $display("FAIL rmid_segs2 got %h %h want 07f 07f", seg_led_1, seg_led_2);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_timing_99();
        test_values();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
